mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the CPU's single shared memory port. Accepts instruction-fetch requests from the IF state (PC address) and data requests from load/store execute states (LDUR/STUR). Grants one request at a time to a fixed-latency synchronous RAM and returns read data with a one-cycle acknowledge per port. Data accesses have priority; a burst limit keeps fetch from starving.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Types and constants shared by the CPU memory-port logic and its future
// peripheral bus controllers.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; counts fixed-latency wait cycles.
// Decrementing stops at zero, so an idle counter simply sits there.
module mem_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values; blocking assignments here would create order races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the CPU's single memory port: data requests win,
// a burst limit lets a waiting fetch in, each access runs IDLE->ACCESS->RESP.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STREAK_W = $clog2(MAX_DATA_BURST) + 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

  state_t              state, state_next;
  logic                owner;
  logic [STREAK_W-1:0] streak, streak_next;
  logic                grant, grant_dm;
  logic                wait_done;

  mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clock      (clock),
    .reset      (reset),
    .load       (grant),
    .load_value (CNT_W'(MEM_LATENCY)),
    .dec        (state == ACCESS),
    .zero       (wait_done)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_dm    = 1'b0;
    streak_next = streak;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          grant      = 1'b1;
          grant_dm   = dm_req && !(if_req && streak == STREAK_MAX);
          state_next = ACCESS;
          // Only data grants that keep a fetch waiting extend the streak.
          if (grant_dm && if_req) begin
            streak_next = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
          end else begin
            streak_next = '0;
          end
        end
      end
      ACCESS:  if (wait_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWNER_IF;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      mem_en <= grant;
      if (grant) begin
        owner    <= grant_dm ? OWNER_DM : OWNER_IF;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        mem_we   <= grant_dm && dm_we;
        if (grant_dm) mem_wdata <= dm_wdata;
      end
      // mem_we still holds the granted access type; fetches are always reads.
      if (state == ACCESS && wait_done && !mem_we) rdata <= mem_rdata;
    end
  end

  assign if_ack = (state == RESP) && (owner == OWNER_IF);
  assign dm_ack = (state == RESP) && (owner == OWNER_DM);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses, hand-timed corner
// sequences, and random traffic checked against a transaction-timing model.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int LAT   = 1;
  localparam int BURST = 4;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          if_req, if_ack, dm_req, dm_we, dm_ack, mem_en, mem_we, busy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, rdata, mem_wdata, mem_rdata;

  logic          l3_if_req, l3_if_ack, l3_dm_req, l3_dm_we, l3_dm_ack;
  logic          l3_mem_en, l3_mem_we, l3_busy;
  logic [AW-1:0] l3_if_addr, l3_dm_addr, l3_mem_addr;
  logic [DW-1:0] l3_dm_wdata, l3_rdata, l3_mem_wdata, l3_mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_DATA_BURST(BURST)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .MAX_DATA_BURST(BURST)) dut_l3 (
    .clock(clock), .reset(reset),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_wdata(l3_dm_wdata),
    .dm_ack(l3_dm_ack), .rdata(l3_rdata), .mem_en(l3_mem_en), .mem_we(l3_mem_we),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  // Power-up RAM contents: two known instructions, a hash elsewhere.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 64'h40) return 64'h0000_0000_F940_03E1;
    if (a == 64'h44) return 64'h0000_0000_8B02_0020;
    return {~a[31:0], a[31:0] ^ 32'hA5C3_0F96};
  endfunction

  logic [DW-1:0] ram [1024];
  logic [1023:0] ram_written = '0;
  logic [DW-1:0] ref_mem [1024];
  logic [1023:0] ref_written = '0;

  function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
    return ram_written[a[11:2]] ? ram[a[11:2]] : rom_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_written[a[11:2]] ? ref_mem[a[11:2]] : rom_word(a);
  endfunction

  // RAM with one-cycle read latency; junk on the read bus outside valid cycles.
  always @(posedge clock) begin
    mem_rdata <= (mem_en && !mem_we) ? ram_read(mem_addr) : {$urandom, $urandom};
    if (mem_en && mem_we) begin
      ram[mem_addr[11:2]]         <= mem_wdata;
      ram_written[mem_addr[11:2]] <= 1'b1;
    end
  end

  logic [DW-1:0] l3_pipe [3];
  always @(posedge clock) begin
    l3_pipe[0] <= (l3_mem_en && !l3_mem_we) ? rom_word(l3_mem_addr) : {$urandom, $urandom};
    l3_pipe[1] <= l3_pipe[0];
    l3_pipe[2] <= l3_pipe[1];
  end
  assign l3_mem_rdata = l3_pipe[2];

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic check1(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    l3_if_req = 1'b0; l3_if_addr = '0;
    l3_dm_req = 1'b0; l3_dm_we = 1'b0; l3_dm_addr = '0; l3_dm_wdata = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check1({tag, ".mem_en"}, mem_en, 1'b0);
    check1({tag, ".mem_we"}, mem_we, 1'b0);
    check({tag, ".mem_addr"}, mem_addr, '0);
    check({tag, ".mem_wdata"}, mem_wdata, '0);
    check({tag, ".rdata"}, rdata, '0);
    check1({tag, ".acks"}, if_ack | dm_ack, 1'b0);
    check1({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check_outputs_zero(tag);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One isolated access, request raised in cycle 0; fields scrambled after grant.
  task automatic run_single(input vec_t v, input string tag);
    logic is_st;
    is_st = (v.port == OWNER_DM) && v.we;
    if (v.port == OWNER_DM) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr; dm_we = 1'b1;
    end
    tick();
    check1({tag, ".mem_en1"}, mem_en, 1'b1);
    check({tag, ".mem_addr1"}, mem_addr, v.addr);
    check1({tag, ".mem_we1"}, mem_we, is_st);
    if (is_st) check({tag, ".mem_wdata1"}, mem_wdata, v.wdata);
    if_addr = ~v.addr; dm_addr = ~v.addr; dm_wdata = ~v.wdata; dm_we = ~dm_we;
    tick();
    check1({tag, ".mem_en2"}, mem_en, 1'b0);
    check1({tag, ".busy2"}, busy, 1'b1);
    check1({tag, ".ack2"}, if_ack | dm_ack, 1'b0);
    tick();
    check1({tag, ".if_ack3"}, if_ack, v.port == OWNER_IF);
    check1({tag, ".dm_ack3"}, dm_ack, v.port == OWNER_DM);
    check({tag, ".rdata3"}, rdata, v.exp_rdata);
    check({tag, ".mem_addr3"}, mem_addr, v.addr);
    idle_inputs();
    tick();
    check1({tag, ".busy4"}, busy, 1'b0);
    check1({tag, ".ack4"}, if_ack | dm_ack, 1'b0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 64'h800 + AW'(8 * $urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    vecs[0] = '{OWNER_IF, 1'b0, 64'h40,  64'h0,                   64'h0000_0000_F940_03E1};
    vecs[1] = '{OWNER_DM, 1'b1, 64'h100, 64'hDEAD_BEEF,           64'h0000_0000_F940_03E1};
    vecs[2] = '{OWNER_DM, 1'b0, 64'h100, 64'h0,                   64'h0000_0000_DEAD_BEEF};
    vecs[3] = '{OWNER_DM, 1'b1, 64'h108, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_DEAD_BEEF};
    vecs[4] = '{OWNER_IF, 1'b0, 64'h44,  64'h0,                   64'h0000_0000_8B02_0020};
    vecs[5] = '{OWNER_DM, 1'b0, 64'h108, 64'h0,                   64'h0123_4567_89AB_CDEF};

    idle_inputs();
    reset = 1'b1;
    #3;
    do_reset("reset");

    for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Collision: data first, fetch waits a full access.
    if_req = 1'b1; if_addr = 64'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
    tick();
    check1("col.mem_en1", mem_en, 1'b1);
    check("col.mem_addr1", mem_addr, 64'h100);
    tick();
    tick();
    check1("col.dm_ack3", dm_ack, 1'b1);
    check1("col.if_ack3", if_ack, 1'b0);
    check("col.rdata3", rdata, 64'hDEAD_BEEF);
    dm_req = 1'b0;
    tick();
    check1("col.mem_en4", mem_en, 1'b0);
    tick();
    check1("col.mem_en5", mem_en, 1'b1);
    check("col.mem_addr5", mem_addr, 64'h44);
    check1("col.mem_we5", mem_we, 1'b0);
    tick();
    tick();
    check1("col.if_ack7", if_ack, 1'b1);
    check("col.rdata7", rdata, 64'h8B02_0020);
    idle_inputs();
    tick();

    // Starvation: both requesters keep asking; fetch gets in after each burst.
    do_reset("reset2");
    if_req = 1'b1; if_addr = 64'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
    begin : starve
      int dm_run, rounds, cycles;
      dm_run = 0; rounds = 0; cycles = 0;
      while (rounds < 2 && cycles < 100) begin
        tick();
        cycles++;
        if (dm_ack) dm_run++;
        if (if_ack) begin
          check_int($sformatf("starve.dm_acks_before_if%0d", rounds), dm_run, BURST);
          dm_run = 0;
          rounds++;
        end
      end
      check_int("starve.rounds_completed", rounds, 2);
    end
    idle_inputs();
    tick();
    tick();

    // Reset in cycle 2 of a load abandons it.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
    tick();
    tick();
    reset = 1'b1;
    #2;
    check_outputs_zero("midrst");
    idle_inputs();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check1($sformatf("midrst.no_ack%0d", c), if_ack | dm_ack | busy, 1'b0);
    end
    v = '{OWNER_DM, 1'b0, 64'h100, 64'h0, 64'h0000_0000_DEAD_BEEF};
    run_single(v, "midrst.reissue");

    // Latency-3 instance: single load.
    l3_dm_req = 1'b1; l3_dm_we = 1'b0; l3_dm_addr = 64'h200;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check1($sformatf("lat3.mem_en.c%0d", c), l3_mem_en, c == 1);
      check1($sformatf("lat3.dm_ack.c%0d", c), l3_dm_ack, c == 5);
      check1($sformatf("lat3.if_ack.c%0d", c), l3_if_ack, 1'b0);
      check1($sformatf("lat3.busy.c%0d", c), l3_busy, c >= 1 && c <= 5);
      if (c == 1) begin
        check("lat3.mem_addr", l3_mem_addr, 64'h200);
        check1("lat3.mem_we", l3_mem_we, 1'b0);
        check("lat3.mem_wdata", l3_mem_wdata, '0);
      end
      if (c == 5) begin
        check("lat3.rdata", l3_rdata, rom_word(64'h200));
        l3_dm_req = 1'b0;
      end
    end

    // Random traffic against a transaction-timing model.
    do_reset("reset3");
    begin : rnd
      int            g, ack_c, free_at, streak_m;
      logic          g_valid, g_port, g_we, take_dm;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_wdata, g_read, exp_rdata;
      g = -100; free_at = 0; streak_m = 0; g_valid = 1'b0;
      g_port = OWNER_IF; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_read = '0;
      exp_rdata = '0;
      for (int k = 0; k < 600; k++) begin
        ack_c = g + 2 + LAT;
        if (g_valid && k == ack_c && !g_we) exp_rdata = g_read;
        check1($sformatf("rnd.busy@%0d", k), busy, g_valid && k > g && k <= ack_c);
        check1($sformatf("rnd.mem_en@%0d", k), mem_en, g_valid && k == g + 1);
        check1($sformatf("rnd.if_ack@%0d", k), if_ack, g_valid && k == ack_c && g_port == OWNER_IF);
        check1($sformatf("rnd.dm_ack@%0d", k), dm_ack, g_valid && k == ack_c && g_port == OWNER_DM);
        check($sformatf("rnd.rdata@%0d", k), rdata, exp_rdata);
        if (g_valid) begin
          check($sformatf("rnd.mem_addr@%0d", k), mem_addr, g_addr);
          check1($sformatf("rnd.mem_we@%0d", k), mem_we, g_we);
          if (g_we) check($sformatf("rnd.mem_wdata@%0d", k), mem_wdata, g_wdata);
        end

        // Requesters: drop the cycle after their ack (data may chain a new one).
        if (if_req && g_valid && k == ack_c + 1 && g_port == OWNER_IF) begin
          if_req = 1'b0;
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = rand_addr();
        end
        if (dm_req && g_valid && k == ack_c + 1 && g_port == OWNER_DM && $urandom_range(0, 1) == 0) begin
          dm_req = 1'b0;
        end else if ((!dm_req && $urandom_range(0, 2) == 0) ||
                     (dm_req && g_valid && k == ack_c + 1 && g_port == OWNER_DM)) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = rand_addr(); dm_wdata = {$urandom, $urandom};
        end
        if (g_valid && k > g && k <= ack_c && $urandom_range(0, 3) == 0) begin
          if (g_port == OWNER_DM) begin
            dm_addr = rand_addr(); dm_wdata = {$urandom, $urandom}; dm_we = ~dm_we;
          end else begin
            if_addr = rand_addr();
          end
        end

        // Model: sample requests whenever the port is free again.
        if (k >= free_at && (if_req || dm_req)) begin
          take_dm = dm_req && !(if_req && streak_m == BURST);
          g = k; g_valid = 1'b1;
          g_port = take_dm ? OWNER_DM : OWNER_IF;
          g_addr = take_dm ? dm_addr : if_addr;
          g_we   = take_dm && dm_we;
          if (take_dm) g_wdata = dm_wdata;
          if (g_we) begin
            ref_mem[g_addr[11:2]]     = g_wdata;
            ref_written[g_addr[11:2]] = 1'b1;
          end else begin
            g_read = ref_read(g_addr);
          end
          if (take_dm && if_req) streak_m = (streak_m < BURST) ? streak_m + 1 : streak_m;
          else streak_m = 0;
          free_at = k + 3 + LAT;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
